// File: rtl/ex_pkg.sv
// Shared types and constants for the RV32I execute stage.
// EX_WIDTH / EX_REG_ADDR_W size the entry structs; the stage parameters must match them.
package ex_pkg;

    localparam int EX_WIDTH      = 32;
    localparam int EX_REG_ADDR_W = 5;

    // Branch condition codes (funct3) as delivered by decode
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Fully resolved entry as produced by ex_resolve
    typedef struct packed {
        logic [EX_WIDTH-1:0]      result;
        logic [EX_REG_ADDR_W-1:0] rd;
        logic                     reg_write;
        logic                     redirect;
        logic [EX_WIDTH-1:0]      target;
    } ex_entry_t;

    // Part of an entry that travels on to the memory stage
    typedef struct packed {
        logic [EX_WIDTH-1:0]      result;
        logic [EX_REG_ADDR_W-1:0] rd;
        logic                     reg_write;
    } ex_wb_t;

endpackage

// File: rtl/ex_resolve.sv
// Combinational branch/jump resolution: taken decision, redirect target,
// result selection and destination write-enable qualification.
module ex_resolve
    import ex_pkg::*;
(
    input  logic [EX_WIDTH-1:0]      alu_out_i,
    input  logic                     alu_zero_i,
    input  logic [EX_WIDTH-1:0]      pc_i,
    input  logic [EX_WIDTH-1:0]      imm_i,
    input  logic [2:0]               funct3_i,
    input  logic                     is_branch_i,
    input  logic                     is_jal_i,
    input  logic                     is_jalr_i,
    input  logic [EX_REG_ADDR_W-1:0] rd_i,
    input  logic                     reg_write_i,
    output ex_entry_t                entry_o
);

    logic code_ok;
    logic taken;
    logic jump;

    // Codes 010/011 are not branches; they must never redirect
    always_comb begin
        code_ok = 1'b0;
        case (funct3_i)
            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: code_ok = 1'b1;
            default:                                          code_ok = 1'b0;
        endcase
    end

    // XOR result for BEQ/BNE, SLT/SLTU result for the ordered compares
    assign taken = is_branch_i && code_ok && (alu_zero_i ^ funct3_i[2] ^ funct3_i[0]);
    assign jump  = is_jal_i || is_jalr_i;

    always_comb begin
        entry_o           = '0;
        entry_o.result    = jump ? (pc_i + EX_WIDTH'(4)) : alu_out_i;
        entry_o.rd        = rd_i;
        entry_o.reg_write = reg_write_i && !is_branch_i && (rd_i != '0);
        entry_o.redirect  = taken || jump;
        entry_o.target    = is_jalr_i ? {alu_out_i[EX_WIDTH-1:1], 1'b0} : (pc_i + imm_i);
    end

endmodule

// File: rtl/ex_stage.sv
// Execute-stage pipeline register: resolves branches/jumps, emits a one-cycle
// redirect after acceptance and forwards results over valid/ready.
// EX_STAGE_SKID_EN adds a skid slot so in_ready becomes a pure register output.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH      = EX_WIDTH,
    parameter int REG_ADDR_W = EX_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_zero,
    input  logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      imm,
    input  logic [2:0]            funct3,
    input  logic                  is_branch,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  redirect_valid,
    output logic [WIDTH-1:0]      redirect_pc
);

    ex_entry_t        in_entry;
    ex_wb_t           in_wb;
    logic             accept;

    ex_wb_t           out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    ex_resolve u_resolve (
        .alu_out_i   (alu_out),
        .alu_zero_i  (alu_zero),
        .pc_i        (pc),
        .imm_i       (imm),
        .funct3_i    (funct3),
        .is_branch_i (is_branch),
        .is_jal_i    (is_jal),
        .is_jalr_i   (is_jalr),
        .rd_i        (rd),
        .reg_write_i (reg_write),
        .entry_o     (in_entry)
    );

    assign in_wb.result    = in_entry.result;
    assign in_wb.rd        = in_entry.rd;
    assign in_wb.reg_write = in_entry.reg_write;

    // Flush wins over a coincident input
    assign accept = in_valid && in_ready && !flush;

    // Redirect tracks acceptance, never output drain
    always_comb begin
        redirect_valid_d = accept && in_entry.redirect;
        redirect_pc_d    = redirect_pc_q;
        if (accept && in_entry.redirect) begin
            redirect_pc_d = in_entry.target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

`ifdef EX_STAGE_SKID_EN
    ex_wb_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry goes first
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_wb;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_wb;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = in_wb;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid      = out_valid_q;
    assign out_result     = out_q.result;
    assign out_rd         = out_q.rd;
    assign out_reg_write  = out_q.reg_write;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table plus scoreboard queue,
// with hand sequences for back-pressure, flush and reset mid-stall.
module tb_ex_stage;

    typedef struct {
        logic [31:0] alu;
        logic        z;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_res;
        logic        e_rw;
        logic        e_redir;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 14;
`ifdef EX_STAGE_SKID_EN
    localparam int EXP_BP = 2;
`else
    localparam int EXP_BP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [4:0]  rd;
    logic        reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[NV];
    vec_t drv;
    vec_t q[$];

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_out        (alu_out),
        .alu_zero       (alu_zero),
        .pc             (pc),
        .imm            (imm),
        .funct3         (funct3),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .rd             (rd),
        .reg_write      (reg_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic z, input logic [31:0] p,
                                input logic [31:0] i, input logic [2:0] f, input logic b,
                                input logic j, input logic jr, input logic [4:0] r,
                                input logic w, input logic [31:0] er, input logic ew,
                                input logic ed, input logic [31:0] ep);
        vec_t v;
        v.alu = a; v.z = z; v.pc = p; v.imm = i; v.f3 = f; v.br = b; v.jal = j;
        v.jalr = jr; v.rd = r; v.rw = w; v.e_res = er; v.e_rw = ew; v.e_redir = ed;
        v.e_pc = ep;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        drv       = v;
        alu_out   = v.alu;
        alu_zero  = v.z;
        pc        = v.pc;
        imm       = v.imm;
        funct3    = v.f3;
        is_branch = v.br;
        is_jal    = v.jal;
        is_jalr   = v.jalr;
        rd        = v.rd;
        reg_write = v.rw;
        in_valid  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge
    logic        redir_exp = 1'b0;
    logic [31:0] redir_pc_exp = '0;
    logic        prev_acc_free = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    logic [4:0]  prev_rd = '0;
    logic        prev_rw = 1'b0;

    always @(negedge clk) begin : monitor
        vec_t e;
        logic acc;
        if (rst) begin
            q.delete();
            redir_exp     = 1'b0;
            prev_acc_free = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, redir_exp});
            if (redir_exp) chk("redirect_pc", redirect_pc, redir_pc_exp);
            if (prev_acc_free) chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
            if (prev_stall) begin
                chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_out_result", out_result, prev_res);
                chk("hold_out_rd", {27'd0, out_rd}, {27'd0, prev_rd});
                chk("hold_out_reg_write", {31'd0, out_reg_write}, {31'd0, prev_rw});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_result", out_result, e.e_res);
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.e_rw});
                end
            end
            if (flush) q.delete();
            acc = in_valid && in_ready && !flush;
            if (acc) q.push_back(drv);
            redir_exp     = acc && drv.e_redir;
            redir_pc_exp  = drv.e_pc;
            prev_acc_free = acc && (!out_valid || out_ready);
            prev_stall    = out_valid && !out_ready && !flush;
            prev_res      = out_result;
            prev_rd       = out_rd;
            prev_rw       = out_reg_write;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        int nacc;
        //           alu           z  pc            imm           f3      br jal jalr rd  rw  e_res         e_rw e_redir e_pc
        vecs[0]  = mk(32'h0,        1, 32'h100,      32'h20,       3'b000, 1, 0, 0, 5'd5, 0, 32'h0,        0, 1, 32'h120);
        vecs[1]  = mk(32'h1,        0, 32'h200,      32'h10,       3'b101, 1, 0, 0, 5'd6, 0, 32'h1,        0, 0, 32'h0);
        vecs[2]  = mk(32'h2003,     0, 32'h40,       32'h3,        3'b000, 0, 0, 1, 5'd1, 1, 32'h44,       1, 1, 32'h2002);
        vecs[3]  = mk(32'hDEADBEEF, 0, 32'h300,      32'h0,        3'b000, 0, 0, 0, 5'd7, 1, 32'hDEADBEEF, 1, 0, 32'h0);
        vecs[4]  = mk(32'h55,       0, 32'h304,      32'h0,        3'b000, 0, 0, 0, 5'd0, 1, 32'h55,       0, 0, 32'h0);
        vecs[5]  = mk(32'h123,      0, 32'hFFFFFFFC, 32'h8,        3'b000, 0, 1, 0, 5'd1, 1, 32'h0,        1, 1, 32'h4);
        vecs[6]  = mk(32'h7,        0, 32'h1000,     32'hFFFFFFF0, 3'b001, 1, 0, 0, 5'd2, 1, 32'h7,        0, 1, 32'hFF0);
        vecs[7]  = mk(32'h1,        0, 32'h80,       32'h8,        3'b100, 1, 0, 0, 5'd0, 0, 32'h1,        0, 1, 32'h88);
        vecs[8]  = mk(32'h0,        1, 32'h90,       32'h8,        3'b110, 1, 0, 0, 5'd0, 0, 32'h0,        0, 0, 32'h0);
        vecs[9]  = mk(32'h0,        1, 32'h10,       32'h4,        3'b111, 1, 0, 0, 5'd0, 0, 32'h0,        0, 1, 32'h14);
        vecs[10] = mk(32'h0,        1, 32'h20,       32'h4,        3'b010, 1, 0, 0, 5'd3, 0, 32'h0,        0, 0, 32'h0);
        vecs[11] = mk(32'h5,        0, 32'h20,       32'h4,        3'b011, 1, 0, 0, 5'd3, 0, 32'h5,        0, 0, 32'h0);
        vecs[12] = mk(32'h9,        0, 32'h30,       32'h4,        3'b000, 1, 0, 0, 5'd3, 0, 32'h9,        0, 0, 32'h0);
        vecs[13] = mk(32'h77,       0, 32'h500,      32'h100,      3'b000, 0, 1, 0, 5'd0, 1, 32'h504,      0, 1, 32'h600);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_out = '0; alu_zero = 1'b0; pc = '0; imm = '0; funct3 = '0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; rd = '0; reg_write = 1'b0;
        drv = vecs[0];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Full-throughput table sweep
        step();
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("tp_drain_empty", q.size(), 32'd0);

        // Back-pressure for three cycles
        out_ready = 1'b0;
        k = 2;
        nacc = 0;
        for (int c = 0; c < 3; c++) begin
            apply(vecs[k]);
            @(negedge clk);
            if (in_ready) begin
                nacc++;
                k++;
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", nacc, EXP_BP);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        repeat (4) step();
        chk("bp_drain_empty", q.size(), 32'd0);

        // Flush a stalled entry together with an incoming taken branch
        out_ready = 1'b0;
        apply(vecs[3]);
        step();
        in_valid = 1'b0;
        step();
        apply(vecs[0]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_queue_empty", q.size(), 32'd0);

        // Reset while an entry is stalled
        out_ready = 1'b0;
        apply(vecs[4]);
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstall_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstall_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rstall_out_reg_write", {31'd0, out_reg_write}, 32'd0);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage pipeline register for the RV32I core. It sits directly downstream of the ALU and consumes `alu_out`/`alu_zero` together with the instruction metadata from decode. It resolves conditional branches and jumps, computes the link value and redirect target, and forwards a registered result to the memory stage over a valid/ready handshake. It can stall under back-pressure and flush under control.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; must match the ALU's `WIDTH`.
- `REG_ADDR_W`, 5, destination-register index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discards all held and incoming entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `alu_out`  in  WIDTH  ALU result for this entry.
- `alu_zero`  in  1  ALU zero flag.
- `pc`  in  WIDTH  instruction address.
- `imm`  in  WIDTH  sign-extended immediate.
- `funct3`  in  3  branch condition code.
- `is_branch`  in  1  conditional branch.
- `is_jal`  in  1  JAL.
- `is_jalr`  in  1  JALR.
- `rd`  in  REG_ADDR_W  destination register.
- `reg_write`  in  1  entry writes `rd`.
- `out_valid`  out  1  result entry valid.
- `out_ready`  in  1  memory stage accepts.
- `out_result`  out  WIDTH  `alu_out`, or `pc+4` for jumps.
- `out_rd`  out  REG_ADDR_W  registered `rd`.
- `out_reg_write`  out  1  registered `reg_write`; forced 0 when `rd==0`.
- `redirect_valid`  out  1  one-cycle pulse: fetch must redirect.
- `redirect_pc`  out  WIDTH  target address; valid only with `redirect_valid`.

## Operation
- **Accept.** An entry is accepted on a cycle with `in_valid && in_ready && !flush`.
- **Condition rule.** Upstream configures the ALU as follows:
  - BEQ/BNE use XOR (op 100).
  - BLT/BGE use signed less-than (op 010).
  - BLTU/BGEU use unsigned less-than (op 011).
- **Branch taken.** `taken = is_branch && (alu_zero ^ funct3[2] ^ funct3[0])`. Results per code:
  - 000 (BEQ): taken when zero.
  - 001 (BNE): taken when nonzero.
  - 100/110 (BLT/BLTU): taken when nonzero.
  - 101/111 (BGE/BGEU): taken when zero.
  - 010 and 011: never taken.
- **Targets.** Arithmetic is modulo 2^WIDTH; carries are dropped.
  - Branch and JAL: `pc + imm`.
  - JALR: `alu_out & ~1`.
- **Result.**
  - Jumps: `pc + 4`.
  - Branches: `out_reg_write` is 0.
  - Otherwise: `alu_out`.
- **Redirect.** Fires for a taken branch or any jump. `redirect_valid` pulses exactly once per accepted entry, in the cycle after acceptance, regardless of `out_ready`.
- **Flush.**
  - Clears every valid bit next cycle.
  - Suppresses any redirect pulse not yet emitted.
  - Flush with `in_valid` in the same cycle: input is dropped, and flush wins.
- **Zero destination.** `rd == 0` yields `out_reg_write = 0`.

## Timing
- Latency is one cycle from accept to `out_valid`.
- Output fields are held stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid`, `redirect_valid`, `out_reg_write` = 0.
  - `out_result`, `out_rd`, `redirect_pc` = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- A reset mid-stall drops the entry. No redirect is emitted.
- Simultaneous `out_ready` and accept pass through at full throughput, one entry per cycle.

## Configuration
`EX_STAGE_SKID_EN` selects how `in_ready` is generated:
- **Defined:** a two-entry skid buffer.
  - `in_ready` is a pure register output, equal to "skid slot empty".
  - Full throughput is sustained.
  - An entry arriving while the output is stalled lands in the skid slot.
  - The skid entry drains to the output when `out_ready` rises.
- **Undefined:** a single register.
  - `in_ready = !out_valid || out_ready` (combinational path from `out_ready`).
- In both variants, redirect emission follows acceptance, not output drain.

## Structure
Shared package `ex_pkg` holds:
- Branch funct3 constants.
- A packed struct `ex_entry_t`: result, rd, reg_write, redirect flag, redirect target.

Sub-module: `ex_resolve`, a combinational unit that computes taken, target and result from the inputs. The stage top holds the registers and the optional skid slot.

## Test plan
- **Branch taken.** BEQ, `alu_zero=1`, `pc=0x100`, `imm=0x20` → next cycle `redirect_valid=1`, `redirect_pc=0x120`, `out_reg_write=0`.
- **Branch not taken.** BGE, `alu_zero=0` → no redirect; `out_valid=1` next cycle.
- **JALR.** `alu_out=0x2003`, `pc=0x40`, `rd=1` → `redirect_pc=0x2002`, `out_result=0x44`, `out_reg_write=1`.
- **Back-pressure.** Hold `out_ready=0` for 3 cycles → `out_result` stable. With skid: exactly 2 entries accepted, then `in_ready=0`. Without skid: 1 entry accepted. Release → entries drain in order with no loss.
- **Flush.** Flush with a stalled entry plus a coincident `in_valid` → next cycle `out_valid=0`; no redirect from either entry.
- **Zero destination and wrap.** `rd=0`, `reg_write=1` → `out_reg_write=0`. Separately, `pc=0xFFFFFFFC`, `imm=8`, jump → `redirect_pc=0x4`.
